// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 serial loader: register selects, control reset mask, FSM states.
package mmc1_pkg;

  localparam logic [1:0] SEL_CONTROL = 2'b00;
  localparam logic [1:0] SEL_CHR0    = 2'b01;
  localparam logic [1:0] SEL_CHR1    = 2'b10;
  localparam logic [1:0] SEL_PRG     = 2'b11;

  localparam logic [4:0] CTRL_RESET_MASK = 5'b01100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/mmc1_sync.sv
// Reset-valued multi-flop synchronizer for one asynchronous CPU bus signal.
module mmc1_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 CPU-write front end: synchronizes the bus, captures $8000-$FFFF writes and
// runs the 5-write serial protocol, emitting one-cycle register-update strobes.
module mmc1_serial_loader
  import mmc1_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter bit          IGNORE_BACK_TO_BACK = 1'b1
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       CPU_M2,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_A14,
  input  logic       CPU_A13,
  input  logic       CPU_D0,
  input  logic       CPU_D7,
  output logic       REG_WE,
  output logic [1:0] REG_SEL,
  output logic [4:0] REG_DATA,
  output logic       CTRL_RESET,
  output logic [2:0] SHIFT_CNT
);

  logic m2_s, romsel_n_s, rw_n_s;

  mmc1_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_m2 (
    .clk(CLK), .rst_n(nRESET), .d(CPU_M2), .q(m2_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_romsel (
    .clk(CLK), .rst_n(nRESET), .d(nCPU_ROMSEL), .q(romsel_n_s));
  mmc1_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rw (
    .clk(CLK), .rst_n(nRESET), .d(nCPU_RW), .q(rw_n_s));

  state_e     state_q, state_d;
  logic       m2_prev_q, m2_prev_d;
  logic [1:0] cap_sel_q, cap_sel_d;
  logic       cap_d0_q, cap_d0_d;
  logic       cap_d7_q, cap_d7_d;
  logic [4:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       b2b_q, b2b_d;
  logic       reg_we_q, reg_we_d;
  logic       ctrl_reset_q, ctrl_reset_d;
  logic [1:0] reg_sel_q, reg_sel_d;
  logic [4:0] reg_data_q, reg_data_d;

  logic       wr_cond, m2_fall;
  logic [4:0] shift_next;

  assign wr_cond    = m2_s & ~romsel_n_s & ~rw_n_s;
  assign m2_fall    = m2_prev_q & ~m2_s;
  assign shift_next = {cap_d0_q, shift_q[4:1]};

  // The write is evaluated on the WR->COMMIT edge so the registered strobes are
  // visible during the COMMIT cycle, SYNC_STAGES+1 clocks after the M2 fall.
  always_comb begin
    state_d      = state_q;
    m2_prev_d    = m2_s;
    cap_sel_d    = cap_sel_q;
    cap_d0_d     = cap_d0_q;
    cap_d7_d     = cap_d7_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    b2b_d        = b2b_q;
    reg_we_d     = 1'b0;
    ctrl_reset_d = 1'b0;
    reg_sel_d    = reg_sel_q;
    reg_data_d   = reg_data_q;

    case (state_q)
      ST_IDLE: begin
        if (m2_fall) begin
          b2b_d = 1'b0;
        end
        if (wr_cond) begin
          cap_sel_d = {CPU_A14, CPU_A13};
          cap_d0_d  = CPU_D0;
          cap_d7_d  = CPU_D7;
          state_d   = ST_WR;
        end
      end
      ST_WR: begin
        if (wr_cond) begin
          cap_sel_d = {CPU_A14, CPU_A13};
          cap_d0_d  = CPU_D0;
          cap_d7_d  = CPU_D7;
        end else if (m2_fall) begin
          state_d = ST_COMMIT;
          if (b2b_q && IGNORE_BACK_TO_BACK) begin
            b2b_d = 1'b0;
          end else begin
            b2b_d = 1'b1;
            if (cap_d7_q) begin
              shift_d      = '0;
              cnt_d        = '0;
              ctrl_reset_d = 1'b1;
            end else if (cnt_q == 3'd4) begin
              reg_data_d = shift_next;
              reg_sel_d  = cap_sel_q;
              reg_we_d   = 1'b1;
              shift_d    = '0;
              cnt_d      = '0;
            end else begin
              shift_d = shift_next;
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= ST_IDLE;
      m2_prev_q    <= 1'b0;
      cap_sel_q    <= '0;
      cap_d0_q     <= 1'b0;
      cap_d7_q     <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      b2b_q        <= 1'b0;
      reg_we_q     <= 1'b0;
      ctrl_reset_q <= 1'b0;
      reg_sel_q    <= SEL_CONTROL;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      m2_prev_q    <= m2_prev_d;
      cap_sel_q    <= cap_sel_d;
      cap_d0_q     <= cap_d0_d;
      cap_d7_q     <= cap_d7_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      b2b_q        <= b2b_d;
      reg_we_q     <= reg_we_d;
      ctrl_reset_q <= ctrl_reset_d;
      reg_sel_q    <= reg_sel_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign REG_WE     = reg_we_q;
  assign REG_SEL    = reg_sel_q;
  assign REG_DATA   = reg_data_q;
  assign CTRL_RESET = ctrl_reset_q;
  assign SHIFT_CNT  = cnt_q;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Bench for mmc1_serial_loader: two instances (SYNC=2/ignore on, SYNC=3/ignore off)
// share one CPU bus and are checked each cycle against a write-level model.
module tb_mmc1_serial_loader;

  logic CLK = 1'b0;
  logic nRESET, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7;

  logic       we_a, cr_a, we_b, cr_b;
  logic [1:0] sel_a, sel_b;
  logic [4:0] data_a, data_b;
  logic [2:0] cnt_a, cnt_b;

  mmc1_serial_loader #(.SYNC_STAGES(2), .IGNORE_BACK_TO_BACK(1'b1)) dut_a (
    .CLK(CLK), .nRESET(nRESET), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL),
    .nCPU_RW(nCPU_RW), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0),
    .CPU_D7(CPU_D7), .REG_WE(we_a), .REG_SEL(sel_a), .REG_DATA(data_a),
    .CTRL_RESET(cr_a), .SHIFT_CNT(cnt_a));

  mmc1_serial_loader #(.SYNC_STAGES(3), .IGNORE_BACK_TO_BACK(1'b0)) dut_b (
    .CLK(CLK), .nRESET(nRESET), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL),
    .nCPU_RW(nCPU_RW), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0),
    .CPU_D7(CPU_D7), .REG_WE(we_b), .REG_SEL(sel_b), .REG_DATA(data_b),
    .CTRL_RESET(cr_b), .SHIFT_CNT(cnt_b));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic       o_we[2], o_cr[2];
  logic [1:0] o_sel[2];
  logic [4:0] o_data[2];
  logic [2:0] o_cnt[2];
  assign o_we[0] = we_a;     assign o_we[1] = we_b;
  assign o_cr[0] = cr_a;     assign o_cr[1] = cr_b;
  assign o_sel[0] = sel_a;   assign o_sel[1] = sel_b;
  assign o_data[0] = data_a; assign o_data[1] = data_b;
  assign o_cnt[0] = cnt_a;   assign o_cnt[1] = cnt_b;

  // Model: per instance, the list of accepted bits plus the pending output update.
  bit         prev_acc[2];
  int         nbits[2];
  logic [4:0] acc[2];
  bit         pend[2];
  int         due[2];
  bit         p_we[2], p_cr[2];
  logic [2:0] p_cnt[2], v_cnt[2];
  logic [1:0] p_sel[2], v_sel[2];
  logic [4:0] p_data[2], v_data[2];

  function automatic int sync_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit ign_of(input int k);
    return (k == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      prev_acc[k] = 1'b0; nbits[k] = 0; acc[k] = '0; pend[k] = 1'b0;
      v_cnt[k] = '0; v_sel[k] = '0; v_data[k] = '0;
    end
  endtask

  task automatic model_fall(input bit wr, input logic [1:0] sel, input bit d0, input bit d7);
    for (int k = 0; k < 2; k++) begin
      if (wr && !(ign_of(k) && prev_acc[k])) begin
        prev_acc[k] = 1'b1;
        p_we[k] = 1'b0; p_cr[k] = 1'b0;
        p_sel[k] = v_sel[k]; p_data[k] = v_data[k];
        if (d7) begin
          nbits[k] = 0; acc[k] = '0; p_cr[k] = 1'b1;
        end else begin
          acc[k] = acc[k] | (5'(d0) << nbits[k]);
          nbits[k] = nbits[k] + 1;
          if (nbits[k] == 5) begin
            p_we[k] = 1'b1; p_sel[k] = sel; p_data[k] = acc[k];
            nbits[k] = 0; acc[k] = '0;
          end
        end
        p_cnt[k] = 3'(nbits[k]);
        pend[k] = 1'b1;
        due[k] = cyc + sync_of(k) + 1;
      end else begin
        prev_acc[k] = 1'b0;
      end
    end
  endtask

  int we_cnt[2], cr_cnt[2], we_cyc[2];

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit ew;
        bit ec;
        ew = 1'b0;
        ec = 1'b0;
        if (pend[k] && cyc == due[k]) begin
          v_cnt[k] = p_cnt[k]; v_sel[k] = p_sel[k]; v_data[k] = p_data[k];
          ew = p_we[k]; ec = p_cr[k]; pend[k] = 1'b0;
        end
        checks++;
        if (o_we[k] !== ew || o_cr[k] !== ec || o_sel[k] !== v_sel[k] ||
            o_data[k] !== v_data[k] || o_cnt[k] !== v_cnt[k]) begin
          errors++;
          $display("FAIL cycle_cmp dut%0d cyc %0d: got we=%b cr=%b sel=%b data=%b cnt=%0d, want we=%b cr=%b sel=%b data=%b cnt=%0d",
                   k, cyc, o_we[k], o_cr[k], o_sel[k], o_data[k], o_cnt[k],
                   ew, ec, v_sel[k], v_data[k], v_cnt[k]);
        end
        if (o_we[k] === 1'b1) begin we_cnt[k]++; we_cyc[k] = cyc; end
        if (o_cr[k] === 1'b1) cr_cnt[k]++;
      end
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int last_fall;

  // One M2 period: 4 CLK high, 5 CLK low. Address/data stay put after the fall.
  task automatic cpu_cycle(input bit rom, input bit wr, input bit abort,
                           input logic [1:0] sel, input bit d0, input bit d7);
    CPU_A14 = sel[1]; CPU_A13 = sel[0]; CPU_D0 = d0; CPU_D7 = d7;
    nCPU_RW = ~wr;
    CPU_M2 = 1'b1;
    nCPU_ROMSEL = ~rom;
    if (abort) begin
      tick(2);
      nCPU_ROMSEL = 1'b1;
      tick(2);
    end else begin
      tick(4);
    end
    CPU_M2 = 1'b0; nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
    last_fall = cyc;
    model_fall(rom && wr && !abort, sel, d0, d7);
    tick(5);
  endtask

  task automatic wr_rom(input logic [1:0] sel, input bit d0, input bit d7);
    cpu_cycle(1'b1, 1'b1, 1'b0, sel, d0, d7);
  endtask

  task automatic idle_cycle();
    cpu_cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic wr_spaced(input logic [1:0] sel, input bit d0, input bit d7);
    wr_rom(sel, d0, d7);
    idle_cycle();
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    model_reset();
    tick(3);
    nRESET = 1'b1;
    tick(2);
  endtask

  initial begin
    int cr0, we0;
    logic [4:0] pat;
    for (int k = 0; k < 2; k++) begin we_cnt[k] = 0; cr_cnt[k] = 0; we_cyc[k] = 0; end
    CPU_M2 = 1'b0; nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
    CPU_A14 = 1'b0; CPU_A13 = 1'b0; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
    do_reset();
    chk_en = 1'b1;
    lit("reset_we", int'(we_a), 0);
    lit("reset_sel", int'(sel_b), 0);
    lit("reset_data", int'(data_a), 0);
    lit("reset_cnt", int'(cnt_b), 0);

    // $E000, D0 = 1,0,1,1,0
    pat = 5'b01101;
    for (int i = 0; i < 4; i++) wr_spaced(2'b11, pat[i], 1'b0);
    wr_rom(2'b11, pat[4], 1'b0);
    lit("latency_sync2", we_cyc[0] - last_fall, 3);
    lit("latency_sync3", we_cyc[1] - last_fall, 4);
    idle_cycle();
    lit("t1_data", int'(data_a), 13);
    lit("t1_sel", int'(sel_a), 3);
    lit("t1_cnt", int'(cnt_a), 0);
    lit("t1_we_count", we_cnt[1], 1);

    // Three data writes then $80 to $8000, then five writes to $A000
    for (int i = 0; i < 3; i++) wr_spaced(2'b00, 1'b1, 1'b0);
    lit("t2_cnt3", int'(cnt_a), 3);
    cr0 = cr_cnt[0]; we0 = we_cnt[0];
    wr_spaced(2'b00, 1'b0, 1'b1);
    lit("t2_ctrl_reset", cr_cnt[0] - cr0, 1);
    lit("t2_no_we", we_cnt[0] - we0, 0);
    lit("t2_cnt0", int'(cnt_a), 0);
    pat = 5'b10010;
    for (int i = 0; i < 5; i++) wr_spaced(2'b01, pat[i], 1'b0);
    lit("t2_sel", int'(sel_a), 1);
    lit("t2_data", int'(data_b), 18);

    // Reset after the 4th write
    for (int i = 0; i < 4; i++) wr_spaced(2'b10, 1'b1, 1'b0);
    lit("t3_cnt4", int'(cnt_b), 4);
    do_reset();
    lit("t3_cnt_after_reset", int'(cnt_a), 0);
    pat = 5'b10011;
    for (int i = 0; i < 5; i++) wr_spaced(2'b10, pat[i], 1'b0);
    lit("t3_data", int'(data_a), 19);
    lit("t3_sel", int'(sel_a), 2);

    // Non-ROM write, ROM read, aborted write: no effect
    wr_spaced(2'b11, 1'b1, 1'b0);
    wr_spaced(2'b11, 1'b0, 1'b0);
    cr0 = cr_cnt[0];
    cpu_cycle(1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    cpu_cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    cpu_cycle(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    lit("t4_cnt_held", int'(cnt_a), 2);
    lit("t4_no_ctrl_reset", cr_cnt[0] - cr0, 0);
    pat = 5'b00100;
    for (int i = 0; i < 3; i++) wr_spaced(2'b11, pat[i], 1'b0);
    lit("t4_data", int'(data_b), 17);

    // Read-modify-write style back-to-back writes
    do_reset();
    wr_rom(2'b00, 1'b1, 1'b0);
    wr_rom(2'b00, 1'b0, 1'b0);
    lit("t5_cnt_ignore", int'(cnt_a), 1);
    lit("t5_cnt_noignore", int'(cnt_b), 2);
    idle_cycle();
    wr_rom(2'b00, 1'b1, 1'b0);
    wr_rom(2'b00, 1'b0, 1'b1);
    lit("t5_d7_ignored", int'(cnt_a), 2);
    lit("t5_d7_taken", int'(cnt_b), 0);
    wr_rom(2'b00, 1'b1, 1'b0);
    lit("t5_after_ignore", int'(cnt_a), 3);
    lit("t5_after_ignore_b", int'(cnt_b), 1);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
